// File: rtl/counter_mod_n_pkg.sv
// Shared constants for the modulo-N counter family.
// State encoding, default sizing and a width helper.
package counter_pkg;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Bits needed to hold the range 0..mod-1.
  function automatic int width_for(input int mod);
    return (mod < 2) ? 1 : $clog2(mod);
  endfunction

  localparam int DEF_MOD   = 100;
  localparam int DEF_WIDTH = width_for(DEF_MOD);

endpackage

// File: rtl/counter_mod_n.sv
// Parametrised modulo-N up/down counter with
// wrap/saturate, one-shot and cascade outputs.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int MOD      = DEF_MOD,
  parameter int WIDTH    = DEF_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_oneshot,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);

  logic             r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_done;

  logic             w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_limit;
  logic             w_at_limit;

  // Limit depends on direction; terminal count feeds the next stage.
  always_comb begin
    w_limit    = i_up ? LP_MAX : '0;
    w_at_limit = (r_cnt == w_limit);
    o_tc       = i_en & w_at_limit & (r_state == ST_RUN);
  end

  // Next-state and datapath: clear beats load beats counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;
    if (i_clear) begin
      w_cnt_nxt   = '0;
      w_state_nxt = ST_RUN;
      w_done_nxt  = 1'b0;
    end else if (i_load) begin
      w_cnt_nxt   = (i_load_val > LP_MAX) ? LP_MAX : i_load_val;
      w_state_nxt = ST_RUN;
      w_done_nxt  = 1'b0;
    end else if (r_state == ST_RUN && i_en) begin
      if (!w_at_limit) begin
        w_cnt_nxt = i_up ? r_cnt + WIDTH'(1)
                         : r_cnt - WIDTH'(1);
      end else if (i_oneshot) begin
        w_state_nxt = ST_HOLD;
        w_done_nxt  = 1'b1;
      end else if (!SATURATE) begin
        w_cnt_nxt  = i_up ? '0 : LP_MAX;
        w_wrap_nxt = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Count, wrap pulse and done flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = r_wrap;
  assign o_done = r_done;

endmodule
